// File: rtl/scan_refresh_counter.sv
// Display refresh scanner: prescaled scan tick that steps a digit index over lit digits and drives active-low anodes.
// Latency: outputs are registered; digit_idx, tick, frame_done and anode_n all reflect a step on the edge where it occurs.
// Backpressure: none; scan_en=0 freezes all state. Optional macro SCAN_BLANKING_EN blanks anodes for BLANK_CYCLES after each step.
module scan_refresh_counter #(
  parameter int DIVIDER      = 50000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int PRE_W = $clog2(DIVIDER)
) (
  input  logic                  clkin,
  input  logic                  scan_reset,
  input  logic                  scan_en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  tick,
  output logic                  frame_done
);

  localparam logic [PRE_W-1:0] PRESC_MAX = PRE_W'(DIVIDER - 1);
  localparam logic [PRE_W-1:0] BLANK_LIM = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

`ifdef SCAN_BLANKING_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [PRE_W-1:0]      presc;
  logic [PRE_W-1:0]      presc_nxt;
  logic                  step;
  logic                  found;
  logic                  wrap;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      scan_j;
  logic [IDX_W-1:0]      idx_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  // Prescaler: counts while enabled, wraps explicitly at DIVIDER-1 and strobes a step on the wrap
  always_comb begin
    step      = scan_en && (presc == PRESC_MAX);
    presc_nxt = presc;
    if (scan_en) begin
      presc_nxt = step ? '0 : presc + PRE_W'(1);
    end
  end

  // Search the next lit digit after the current one; the current digit is tried last
  always_comb begin
    found  = 1'b0;
    cand   = digit_idx;
    scan_j = digit_idx;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      scan_j = (scan_j == IDX_MAX) ? '0 : scan_j + IDX_W'(1);
      if (!found && digit_mask[scan_j]) begin
        found = 1'b1;
        cand  = scan_j;
      end
    end
  end

  // Next index, frame wrap, and the anode pattern built from next-state values
  always_comb begin
    idx_nxt   = (step && found) ? cand : digit_idx;
    wrap      = step && found && (cand <= digit_idx);
    anode_nxt = '1;
    if (digit_mask[idx_nxt] && !(BLANK_ON && (presc_nxt < BLANK_LIM))) begin
      anode_nxt[idx_nxt] = 1'b0;
    end
  end

  // State and output registers; reset aborts any step in progress
  always_ff @(posedge clkin) begin
    if (scan_reset) begin
      presc      <= '0;
      digit_idx  <= '0;
      anode_n    <= '1;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      digit_idx  <= idx_nxt;
      anode_n    <= anode_nxt;
      tick       <= step;
      frame_done <= wrap;
    end
  end

endmodule
